// File: rtl/rst_sequencer_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package rst_seq_pkg;

  localparam int STATE_W = 3;

  localparam int DEF_MIN_WIDTH = 2;
  localparam int DEF_GAP       = 4;
  localparam int DEF_RECOVERY  = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    STAGGER = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/rst_sequencer_if.sv
// Request handshake and reset/status outputs of the reset sequencer.
interface rst_sequencer_if #(
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 8
) ();

  logic               req_valid;
  logic               req_ready;
  logic [CNT_W-1:0]   req_width;
  logic [NUM_OUT-1:0] req_mask;
  logic [NUM_OUT-1:0] rst_out;
  logic               busy;
  logic               done;

  modport master (
    output req_valid, req_width, req_mask,
    input  req_ready, rst_out, busy, done
  );

  modport slave (
    input  req_valid, req_width, req_mask,
    output req_ready, rst_out, busy, done
  );

endinterface

// File: rtl/rst_sequencer_cnt.sv
// Loadable saturating down-counter shared by the assert, stagger and recovery phases.
module rst_seq_cnt #(
  parameter int               CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             syn_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: asserts a masked group of resets together, then releases
// them one by one in ascending index order, and pulses done when finished.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT   = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int GAP       = DEF_GAP,
  parameter int RECOVERY  = DEF_RECOVERY
) (
  input  logic            clk,
  input  logic            syn_reset,
  rst_sequencer_if.slave  bus
);

  localparam int               IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] MIN_W_C  = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MIN_LD   = CNT_W'(MIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVERY - 1);

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   next_idx;
  logic [NUM_OUT-1:0] released;
  logic [CNT_W-1:0]   req_w_clamped;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_zero;

  // rst_out_q doubles as the set of bits still waiting to be released.
  always_comb begin
    next_idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (rst_out_q[i]) next_idx = IDX_W'(i);
    end
    released           = rst_out_q;
    released[next_idx] = 1'b0;
  end

  assign req_w_clamped = (bus.req_width < MIN_W_C) ? MIN_W_C : bus.req_width;

  always_comb begin
    state_d      = state_q;
    rst_out_d    = rst_out_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          rst_out_d    = bus.req_mask;
          cnt_load     = 1'b1;
          cnt_load_val = req_w_clamped - CNT_W'(1);
          state_d      = (bus.req_mask == '0) ? STAGGER : ASSERT;
        end
      end
      ASSERT, STAGGER: begin
        if (rst_out_q == '0) begin
          state_d = DONE;
        end else if (cnt_zero) begin
          rst_out_d    = released;
          cnt_load     = 1'b1;
          cnt_load_val = (released == '0) ? REC_LD : GAP_LD;
          state_d      = (released == '0) ? RECOVER : STAGGER;
        end
      end
      RECOVER: begin
        if (cnt_zero) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // A block reset restarts a full power-on sequence on every output.
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_q   <= ASSERT;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  rst_seq_cnt #(
    .CNT_W     (CNT_W),
    .RESET_VAL (MIN_LD)
  ) u_cnt (
    .clk       (clk),
    .syn_reset (syn_reset),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .zero      (cnt_zero)
  );

  assign bus.req_ready = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: scripted scenarios plus random
// requests, compared every cycle against an edge-time reference model.
module tb_rst_sequencer;

  localparam int NUM_OUT   = 4;
  localparam int CNT_W     = 8;
  localparam int MIN_WIDTH = 2;
  localparam int GAP       = 4;
  localparam int RECOVERY  = 3;

  logic clk = 1'b0;
  logic syn_reset;

  rst_sequencer_if #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) bus ();

  rst_sequencer #(
    .NUM_OUT   (NUM_OUT),
    .CNT_W     (CNT_W),
    .MIN_WIDTH (MIN_WIDTH),
    .GAP       (GAP),
    .RECOVERY  (RECOVERY)
  ) dut (
    .clk       (clk),
    .syn_reset (syn_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   done_edge = 1 << 30;
  int   clear_t [NUM_OUT];
  logic exp_ready = 1'b0;
  logic accepted  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
               tag, cyc, actual, expected);
    end
  endtask

  // Model: each masked bit k clears at t+W+k*GAP; done follows the last release.
  task automatic startSequence(input int t, input int w, input logic [NUM_OUT-1:0] m);
    int k;
    k = 0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (m[i]) begin
        clear_t[i] = t + w + k * GAP;
        k++;
      end else begin
        clear_t[i] = t;
      end
    end
    done_edge = (k == 0) ? t + 1 : t + w + (k - 1) * GAP + RECOVERY;
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input int width,
                               input logic [NUM_OUT-1:0] mask);
    logic [NUM_OUT-1:0] exp_rst;
    int w_eff;
    syn_reset     = rst;
    bus.req_valid = valid;
    bus.req_width = CNT_W'(width);
    bus.req_mask  = mask;
    @(posedge clk);
    cyc++;
    accepted = 1'b0;
    if (rst) begin
      startSequence(cyc, MIN_WIDTH, '1);
    end else if (valid && exp_ready) begin
      w_eff = (width < MIN_WIDTH) ? MIN_WIDTH : width;
      startSequence(cyc, w_eff, mask);
      accepted = 1'b1;
    end
    exp_ready = (cyc > done_edge);
    for (int i = 0; i < NUM_OUT; i++) exp_rst[i] = (cyc < clear_t[i]);
    @(negedge clk);
    checkOutput("rst_out",   32'(bus.rst_out),   32'(exp_rst));
    checkOutput("done",      32'(bus.done),      32'(cyc == done_edge));
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("busy",      32'(bus.busy),      32'(!exp_ready));
  endtask

  initial begin
    int   guard;
    logic hold;
    int   rw;
    logic [NUM_OUT-1:0] rm;

    // Power-on: three reset edges, then the full sequence plays out.
    repeat (3) applyStimulus(1'b1, 1'b0, 0, '0);
    repeat (20) applyStimulus(1'b0, 1'b0, 0, '0);

    // Sparse mask, with a second request held pending while busy.
    applyStimulus(1'b0, 1'b1, 5, 4'b1010);
    guard = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 3, 4'b0110);
      guard++;
    end while (!accepted && guard < 40);
    repeat (15) applyStimulus(1'b0, 1'b0, 0, '0);

    // Width below the minimum is clamped.
    applyStimulus(1'b0, 1'b1, 0, 4'b0001);
    repeat (8) applyStimulus(1'b0, 1'b0, 0, '0);

    // Empty masks back to back.
    repeat (6) applyStimulus(1'b0, 1'b1, 7, 4'b0000);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, '0);

    // Block reset while releases are in progress.
    applyStimulus(1'b0, 1'b1, 5, 4'b1010);
    repeat (6) applyStimulus(1'b0, 1'b0, 0, '0);
    applyStimulus(1'b1, 1'b0, 0, '0);
    repeat (20) applyStimulus(1'b0, 1'b0, 0, '0);

    // Largest width must not wrap the counter.
    applyStimulus(1'b0, 1'b1, 255, 4'b1000);
    repeat (262) applyStimulus(1'b0, 1'b0, 0, '0);

    // Random requests with occasional block resets.
    hold = 1'b0;
    rw   = 0;
    rm   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold = 1'b1;
        rw   = int'($urandom_range(0, 9));
        rm   = NUM_OUT'($urandom_range(0, 15));
      end
      applyStimulus($urandom_range(0, 59) == 0, hold, rw, rm);
      if (accepted) hold = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
